core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Memory-side responder for the core's two SRAM-style ports: the 64-bit instruction fetch port and the 32-bit load/store port. It owns a word-addressed, dual-read backing array and answers each port with fixed one-cycle read latency. It applies byte-masked writes and decodes the debug print word into a buffered byte stream. It sits directly outside the core top level and is used both in simulation and as the on-chip scratch memory.

## Interface

Parameters:
- DEPTH_WORDS, 4096: backing array size in 32-bit words; power of two, at least 4.
- PRINT_ADDR, 255: word address of the debug print register.
- FIFO_DEPTH, 8: print FIFO entries; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- IN_instrAddr  in  29  fetch address in 8-byte units; selects word pair {2a+1, 2a}.
- IN_instrReadEnable  in  1  active-low fetch enable.
- OUT_instrRaw  out  64  fetch data; word 2a in [31:0], word 2a+1 in [63:32].
- IN_MEM_addr  in  30  data word address.
- IN_MEM_writeData  in  32  store data.
- IN_MEM_writeEnable  in  1  active-low write enable; qualified by chip enable.
- IN_MEM_readEnable  in  1  active-low chip enable for the data port.
- IN_MEM_writeMask  in  4  active-high byte enables; bit i enables byte [8i+7:8i].
- OUT_MEM_readData  out  32  load data.
- OUT_printValid  out  1  print FIFO head valid.
- OUT_printData  out  8  print FIFO head byte.
- IN_printReady  in  1  consumer accepts the head byte.
- OUT_fault  out  1  sticky flag for an out-of-range access.
- OUT_printOverflow  out  1  sticky flag for a byte dropped because the FIFO was full.

## Operation

- Data access occurs when IN_MEM_readEnable is 0.
  - IN_MEM_writeEnable 0 selects a write; 1 selects a read.
  - Ports are ignored when their enable is high.
- A write updates only the bytes enabled in IN_MEM_writeMask. A mask of 0 writes nothing but is still an access.
- Fetch reads the word pair selected by IN_instrAddr.
- A data-port access is out of range when IN_MEM_addr >= DEPTH_WORDS and the address is not PRINT_ADDR.
- A fetch is out of range when 2*IN_instrAddr+1 >= DEPTH_WORDS.
- Out-of-range behaviour:
  - Reads return 0.
  - Writes are dropped.
  - OUT_fault sets and stays set until reset.
- Print register, when MEM_RESP_PRINT_EN is defined:
  - A write to PRINT_ADDR with IN_MEM_writeMask[0]=1 pushes IN_MEM_writeData[7:0] into the FIFO. It does not touch the array.
  - If the FIFO is full, the byte is dropped and OUT_printOverflow sets (sticky).
  - A read of PRINT_ADDR returns {24'b0, free entries[7:0]}, where free entries = FIFO_DEPTH - occupancy.
  - Pop occurs when OUT_printValid and IN_printReady are both 1. OUT_printData is the head byte, shown first-word-fall-through.
  - Push and pop in the same cycle on a full FIFO: the pop frees a slot, so the push is accepted and occupancy stays FIFO_DEPTH.
  - Push and pop in the same cycle on an empty FIFO: the pushed byte becomes visible the next cycle.
- Read-during-write, both ports: a read of a word being written in the same cycle returns the old contents (read-first). This applies to both the data port and the fetch port.
- Array contents are not reset. Only outputs, FIFO pointers and flags are reset.

## Timing

- Read latency is 1 cycle on both ports. Data for an access in cycle N is valid in cycle N+1.
- OUT_instrRaw holds its last value while IN_instrReadEnable is 1. OUT_MEM_readData behaves the same way while there is no read access.
- Write effect is visible to reads issued in cycle N+1.
- The print-register status read reflects occupancy before the pushes and pops of the access cycle.
- OUT_printValid rises 1 cycle after the push that made the FIFO non-empty.
- Reset values:
  - OUT_instrRaw = 0.
  - OUT_MEM_readData = 0.
  - OUT_printValid = 0; OUT_printData = 0.
  - OUT_fault = 0; OUT_printOverflow = 0.
  - FIFO empty.
- Asserting rst mid-operation discards FIFO contents and any pending read result. Writes issued in the reset cycle are dropped.
- FIFO pointers wrap modulo FIFO_DEPTH. Full vs. empty is distinguished by an extra pointer bit.

## Configuration

- MEM_RESP_PRINT_EN defined:
  - Print register, FIFO and OUT_printOverflow are implemented as described.
- MEM_RESP_PRINT_EN undefined:
  - PRINT_ADDR is an ordinary array word, and is out of range if it is >= DEPTH_WORDS.
  - OUT_printValid, OUT_printData and OUT_printOverflow are tied to 0.
  - No FIFO logic is generated.

## Test plan

- Masked write: write 0xAABBCCDD with mask 4'b1111 at word 10, then 0x11223344 with mask 4'b0101, then read word 10 -> 0xAA22CC44 in the cycle after the read.
- Fetch pairing and read-first:
  - With word 20 = 0x1 and word 21 = 0x2, fetch IN_instrAddr=10 -> OUT_instrRaw = 0x00000002_00000001.
  - Fetch the same address while writing 0x5 to word 21 in the same cycle -> old value returned; a refetch returns 0x00000005_00000001.
- Print FIFO (MEM_RESP_PRINT_EN defined, FIFO_DEPTH=8, IN_printReady=0):
  - Write bytes 0x41..0x49 -> 8 bytes stored and OUT_printOverflow=1.
  - Reading PRINT_ADDR returns 0.
  - Raising IN_printReady drains 0x41..0x48 in order, one byte per cycle.
- Out of range (DEPTH_WORDS=4096):
  - Read word 5000 -> 0 and OUT_fault=1.
  - Write word 5000 -> no array word changes.
  - OUT_fault stays 1 until rst.
- Reset mid-stream: with 3 bytes queued, assert rst for 1 cycle -> OUT_printValid=0, all outputs 0, array word 10 still holds its pre-reset value.
- Build without MEM_RESP_PRINT_EN: write 0x12345678 to word 255, read it back -> 0x12345678; OUT_printValid stays 0 throughout.

Source files
------------

// File: rtl/core_mem_responder.sv
// core_mem_responder: scratch memory behind the core's 64-bit fetch port and
// 32-bit load/store port. Word-addressed array, two read ports, one byte-masked
// write port, one-cycle registered read latency on both ports.
// Optional debug print register and byte FIFO: define MEM_RESP_PRINT_EN.
module core_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int PRINT_ADDR  = 255,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] IN_instrAddr,
    input  logic        IN_instrReadEnable,
    output logic [63:0] OUT_instrRaw,
    input  logic [29:0] IN_MEM_addr,
    input  logic [31:0] IN_MEM_writeData,
    input  logic        IN_MEM_writeEnable,
    input  logic        IN_MEM_readEnable,
    input  logic [3:0]  IN_MEM_writeMask,
    output logic [31:0] OUT_MEM_readData,
    output logic        OUT_printValid,
    output logic [7:0]  OUT_printData,
    input  logic        IN_printReady,
    output logic        OUT_fault,
    output logic        OUT_printOverflow
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic          acc, wr, rd, fetch;
    logic          dat_oor, fetch_oor, is_print, arr_we;
    logic [31:0]   fetch_top;
    logic [AW-1:0] dat_idx, fetch_lo, fetch_hi;
    logic [7:0]    print_status;
    logic [31:0]   rd_data_p1;
    logic [63:0]   instr_p1;
    logic          fault;

    // Port decode; every enable on these ports is active-low.
    assign acc   = ~IN_MEM_readEnable;
    assign wr    = acc & ~IN_MEM_writeEnable;
    assign rd    = acc & IN_MEM_writeEnable;
    assign fetch = ~IN_instrReadEnable;

    // Upper word of the fetched pair decides the fetch range check.
    assign fetch_top = {2'b00, IN_instrAddr, 1'b1};
    assign fetch_oor = fetch_top >= DEPTH_L;
    assign dat_oor   = ({2'b00, IN_MEM_addr} >= DEPTH_L) && !is_print;

    assign dat_idx  = IN_MEM_addr[AW-1:0];
    assign fetch_lo = {IN_instrAddr[AW-2:0], 1'b0};
    assign fetch_hi = {IN_instrAddr[AW-2:0], 1'b1};

    // Writes during reset, out of range, or to the print register skip the array.
    assign arr_we = wr && !dat_oor && !is_print && !rst;

    // Byte-masked array write; reads below see the old word (read-first).
    always_ff @(posedge clk) begin
        if (arr_we) begin
            for (int b = 0; b < 4; b++) begin
                if (IN_MEM_writeMask[b]) begin
                    mem[dat_idx][8*b +: 8] <= IN_MEM_writeData[8*b +: 8];
                end
            end
        end
    end

    // ---- stage p1: data-port read result, held when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (rd) begin
            if (dat_oor)       rd_data_p1 <= '0;
            else if (is_print) rd_data_p1 <= {24'h0, print_status};
            else               rd_data_p1 <= mem[dat_idx];
        end
    end

    // ---- stage p1: fetch result, held while fetch is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= '0;
        end else if (fetch) begin
            if (fetch_oor) instr_p1 <= '0;
            else           instr_p1 <= {mem[fetch_hi], mem[fetch_lo]};
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if ((acc && dat_oor) || (fetch && fetch_oor)) begin
            fault <= 1'b1;
        end
    end

    assign OUT_MEM_readData = rd_data_p1;
    assign OUT_instrRaw     = instr_p1;
    assign OUT_fault        = fault;

`ifdef MEM_RESP_PRINT_EN
    localparam int          FW       = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FDEPTH_L = (FW+1)'(FIFO_DEPTH);

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [FW:0] wr_ptr, rd_ptr, occ;
    logic        full, empty, push_req, push, pop, ovf;

    // Extra pointer bit separates full from empty.
    assign is_print     = IN_MEM_addr == 30'(PRINT_ADDR);
    assign occ          = wr_ptr - rd_ptr;
    assign empty        = occ == '0;
    assign full         = occ == FDEPTH_L;
    assign pop          = !empty && IN_printReady;
    assign push_req     = wr && is_print && IN_MEM_writeMask[0];
    assign push         = push_req && (!full || pop);
    assign print_status = 8'(FIFO_DEPTH) - 8'(occ);

    // FIFO pointers and overflow flag; a pop on a full FIFO makes room for a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)                      wr_ptr <= wr_ptr + 1'b1;
            if (pop)                       rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop)  ovf    <= 1'b1;
        end
    end

    // FIFO byte storage; contents are not reset, only the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr[FW-1:0]] <= IN_MEM_writeData[7:0];
        end
    end

    assign OUT_printValid    = !empty;
    assign OUT_printData     = empty ? 8'h00 : fifo_mem[rd_ptr[FW-1:0]];
    assign OUT_printOverflow = ovf;
`else
    wire        unused_ready = IN_printReady;
    wire [31:0] unused_cfg   = 32'(PRINT_ADDR) ^ 32'(FIFO_DEPTH);

    assign is_print          = 1'b0;
    assign print_status      = 8'h00;
    assign OUT_printValid    = 1'b0;
    assign OUT_printData     = 8'h00;
    assign OUT_printOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: a vector table for masked writes and
// reads, then hand-written sequences for fetch pairing, read-first, range
// faults, the print FIFO (when MEM_RESP_PRINT_EN is defined) and reset.
module tb_core_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [28:0] instr_addr = '0;
    logic        instr_re = 1'b1;
    logic [63:0] instr_raw;
    logic [29:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_we = 1'b1;
    logic        mem_re = 1'b1;
    logic [3:0]  mem_mask = '0;
    logic [31:0] mem_rdata;
    logic        print_valid;
    logic [7:0]  print_data;
    logic        print_ready = 1'b0;
    logic        fault;
    logic        print_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [29:0] PA = 30'd255;

    core_mem_responder dut (
        .clk               (clk),
        .rst               (rst),
        .IN_instrAddr      (instr_addr),
        .IN_instrReadEnable(instr_re),
        .OUT_instrRaw      (instr_raw),
        .IN_MEM_addr       (mem_addr),
        .IN_MEM_writeData  (mem_wdata),
        .IN_MEM_writeEnable(mem_we),
        .IN_MEM_readEnable (mem_re),
        .IN_MEM_writeMask  (mem_mask),
        .OUT_MEM_readData  (mem_rdata),
        .OUT_printValid    (print_valid),
        .OUT_printData     (print_data),
        .IN_printReady     (print_ready),
        .OUT_fault         (fault),
        .OUT_printOverflow (print_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, step past the rising edge, go idle.
    task automatic cycle(input logic f_en, input logic [28:0] f_addr,
                         input logic acc, input logic wr, input logic [29:0] addr,
                         input logic [31:0] data, input logic [3:0] mask, input logic rdy);
        @(negedge clk);
        instr_re    = ~f_en;
        instr_addr  = f_addr;
        mem_re      = ~acc;
        mem_we      = ~wr;
        mem_addr    = addr;
        mem_wdata   = data;
        mem_mask    = mask;
        print_ready = rdy;
        @(posedge clk);
        #1;
        instr_re    = 1'b1;
        mem_re      = 1'b1;
        mem_we      = 1'b1;
        mem_mask    = '0;
        print_ready = 1'b0;
    endtask

    task automatic wr_word(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        cycle(1'b0, '0, 1'b1, 1'b1, a, d, m, 1'b0);
    endtask

    task automatic rd_word(input logic [29:0] a);
        cycle(1'b0, '0, 1'b1, 1'b0, a, '0, '0, 1'b0);
    endtask

    task automatic fetch_pair(input logic [28:0] a);
        cycle(1'b1, a, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, instr_raw, 64'h0);
        check({tag, "_rdata"}, {32'h0, mem_rdata}, 64'h0);
        check({tag, "_pvalid"}, {63'h0, print_valid}, 64'h0);
        check({tag, "_pdata"}, {56'h0, print_data}, 64'h0);
        check({tag, "_fault"}, {63'h0, fault}, 64'h0);
        check({tag, "_povf"}, {63'h0, print_ovf}, 64'h0);
    endtask

    typedef struct packed {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1'b1, 30'd10,   32'hAABBCCDD, 4'b1111, 32'h0};
        vecs[1]  = '{1'b1, 30'd10,   32'h11223344, 4'b0101, 32'h0};
        vecs[2]  = '{1'b0, 30'd10,   32'h0,        4'b0000, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 30'd20,   32'h00000001, 4'b1111, 32'h0};
        vecs[4]  = '{1'b1, 30'd21,   32'h00000002, 4'b1111, 32'h0};
        vecs[5]  = '{1'b0, 30'd20,   32'h0,        4'b0000, 32'h00000001};
        vecs[6]  = '{1'b0, 30'd21,   32'h0,        4'b0000, 32'h00000002};
        vecs[7]  = '{1'b1, 30'd12,   32'hCAFEBABE, 4'b1111, 32'h0};
        vecs[8]  = '{1'b1, 30'd12,   32'h00000000, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 30'd12,   32'h0,        4'b0000, 32'hCAFEBABE};
        vecs[10] = '{1'b1, 30'd13,   32'h00000000, 4'b1111, 32'h0};
        vecs[11] = '{1'b1, 30'd13,   32'hFFFFFFFF, 4'b1010, 32'h0};
        vecs[12] = '{1'b0, 30'd13,   32'h0,        4'b0000, 32'hFF00FF00};
        vecs[13] = '{1'b1, 30'd4095, 32'h12345678, 4'b1111, 32'h0};
        vecs[14] = '{1'b1, 30'd4094, 32'h9ABCDEF0, 4'b1111, 32'h0};
        vecs[15] = '{1'b0, 30'd4095, 32'h0,        4'b0000, 32'h12345678};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Vector table: masked writes and reads
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                wr_word(vecs[i].addr, vecs[i].data, vecs[i].mask);
            end else begin
                rd_word(vecs[i].addr);
                check($sformatf("vec%0d_read", i), {32'h0, mem_rdata}, {32'h0, vecs[i].exp});
            end
        end
        check("table_fault", {63'h0, fault}, 64'h0);

        // Read data holds across writes and idle cycles
        wr_word(30'd30, 32'h0, 4'b1111);
        check("rdata_hold_write", {32'h0, mem_rdata}, 64'h12345678);
        idle(1'b0);
        check("rdata_hold_idle", {32'h0, mem_rdata}, 64'h12345678);

        // Fetch pairing, hold, read-first against a same-cycle write
        fetch_pair(29'd10);
        check("fetch_pair", instr_raw, 64'h00000002_00000001);
        idle(1'b0);
        check("fetch_hold", instr_raw, 64'h00000002_00000001);
        cycle(1'b1, 29'd10, 1'b1, 1'b1, 30'd21, 32'h5, 4'b1111, 1'b0);
        check("fetch_read_first", instr_raw, 64'h00000002_00000001);
        fetch_pair(29'd10);
        check("fetch_refetch", instr_raw, 64'h00000005_00000001);
        fetch_pair(29'd2047);
        check("fetch_top_pair", instr_raw, 64'h12345678_9ABCDEF0);
        check("fetch_fault_clear", {63'h0, fault}, 64'h0);

        // Data-port out of range
        wr_word(30'd904, 32'h00000904, 4'b1111);
        rd_word(30'd10);
        check("pre_oor_read", {32'h0, mem_rdata}, 64'hAA22CC44);
        rd_word(30'd5000);
        check("oor_read_zero", {32'h0, mem_rdata}, 64'h0);
        check("oor_fault_set", {63'h0, fault}, 64'h1);
        rd_word(30'd10);
        rd_word(30'd4096);
        check("oor_boundary_zero", {32'h0, mem_rdata}, 64'h0);
        wr_word(30'd5000, 32'h00000BAD, 4'b1111);
        rd_word(30'd904);
        check("oor_write_dropped", {32'h0, mem_rdata}, 64'h00000904);
        repeat (4) idle(1'b0);
        check("fault_sticky", {63'h0, fault}, 64'h1);

`ifdef MEM_RESP_PRINT_EN
        // Print FIFO fill, overflow, status and drain
        check("print_empty_valid", {63'h0, print_valid}, 64'h0);
        rd_word(PA);
        check("print_status_empty", {32'h0, mem_rdata}, 64'h8);
        wr_word(PA, 32'h41, 4'b0001);
        check("print_valid_rise", {63'h0, print_valid}, 64'h1);
        check("print_head_first", {56'h0, print_data}, 64'h41);
        rd_word(PA);
        check("print_status_one", {32'h0, mem_rdata}, 64'h7);
        for (int b = 8'h42; b <= 8'h48; b++) wr_word(PA, 32'(b), 4'b0001);
        check("print_no_ovf_at_full", {63'h0, print_ovf}, 64'h0);
        wr_word(PA, 32'h49, 4'b0001);
        check("print_ovf_set", {63'h0, print_ovf}, 64'h1);
        rd_word(PA);
        check("print_status_full", {32'h0, mem_rdata}, 64'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid%0d", i), {63'h0, print_valid}, 64'h1);
            check($sformatf("drain_byte%0d", i), {56'h0, print_data}, 64'(8'h41 + i));
            idle(1'b1);
        end
        check("drain_empty", {63'h0, print_valid}, 64'h0);

        // Queue three bytes before the mid-stream reset
        wr_word(PA, 32'h61, 4'b0001);
        wr_word(PA, 32'h62, 4'b0001);
        wr_word(PA, 32'h63, 4'b0001);
        check("prereset_valid", {63'h0, print_valid}, 64'h1);
`endif

        // One-cycle reset mid-stream with a write and a fetch in the same cycle
        @(negedge clk);
        rst        = 1'b1;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 30'd10;
        mem_wdata  = 32'h0;
        mem_mask   = 4'b1111;
        instr_re   = 1'b0;
        instr_addr = 29'd10;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_re   = 1'b1;
        mem_we   = 1'b1;
        mem_mask = '0;
        instr_re = 1'b1;
        check_all_zero("midreset");
        rd_word(30'd10);
        check("reset_write_dropped", {32'h0, mem_rdata}, 64'hAA22CC44);

        // Fetch out of range sets the fault after reset cleared it
        fetch_pair(29'd10);
        check("fetch_after_reset", instr_raw, 64'h00000005_00000001);
        fetch_pair(29'd2048);
        check("fetch_oor_zero", instr_raw, 64'h0);
        check("fetch_oor_fault", {63'h0, fault}, 64'h1);

`ifdef MEM_RESP_PRINT_EN
        // Push and pop together on a full FIFO
        for (int b = 8'h70; b <= 8'h77; b++) wr_word(PA, 32'(b), 4'b0001);
        cycle(1'b0, '0, 1'b1, 1'b1, PA, 32'h78, 4'b0001, 1'b1);
        check("fullpp_head", {56'h0, print_data}, 64'h71);
        check("fullpp_no_ovf", {63'h0, print_ovf}, 64'h0);
        rd_word(PA);
        check("fullpp_status", {32'h0, mem_rdata}, 64'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fullpp_byte%0d", i), {56'h0, print_data}, 64'(8'h71 + i));
            idle(1'b1);
        end
        check("fullpp_empty", {63'h0, print_valid}, 64'h0);

        // Mask bit 0 clear: not a push
        wr_word(PA, 32'h99, 4'b1110);
        check("nomask_no_push", {63'h0, print_valid}, 64'h0);
        rd_word(PA);
        check("nomask_status", {32'h0, mem_rdata}, 64'h8);

        // Push and pop together on an empty FIFO
        cycle(1'b0, '0, 1'b1, 1'b1, PA, 32'h55, 4'b0001, 1'b1);
        check("emptypp_valid", {63'h0, print_valid}, 64'h1);
        check("emptypp_byte", {56'h0, print_data}, 64'h55);
        idle(1'b1);
        check("emptypp_drained", {63'h0, print_valid}, 64'h0);
`else
        // Without the print feature PRINT_ADDR is plain memory
        wr_word(PA, 32'h12345678, 4'b1111);
        check("noprint_valid_a", {63'h0, print_valid}, 64'h0);
        rd_word(PA);
        check("noprint_readback", {32'h0, mem_rdata}, 64'h12345678);
        check("noprint_valid_b", {63'h0, print_valid}, 64'h0);
        check("noprint_data", {56'h0, print_data}, 64'h0);
        check("noprint_ovf", {63'h0, print_ovf}, 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
